// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Architectural zero register never creates a data dependency.
  localparam int unsigned REG_ZERO = 0;

  function automatic int md_cnt_width(input int md_cycles);
    return $clog2(md_cycles);
  endfunction

endpackage

// File: rtl/hazard_load_use.sv
// Load-use hazard detect: ID source matches the destination of a load in EX.
module hazard_load_use
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rt,
  output logic            lu_stall
);

  logic [RA_W-1:0] reg_zero_s;
  logic            rs_hit_s;
  logic            rt_hit_s;

  assign reg_zero_s = RA_W'(REG_ZERO);
  assign rs_hit_s   = (ex_rt == id_rs);
  assign rt_hit_s   = id_uses_rt & (ex_rt == id_rt);
  assign lu_stall   = ex_memread & (ex_rt != reg_zero_s) & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline enable/flush generator: mem wait freeze, MUL/DIV occupancy,
// branch squash and load-use bubbles, plus a saturating stall counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16,
  parameter int RA_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [RA_W-1:0]  ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_br_taken,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                  MD_CNT_W = md_cnt_width(MD_CYCLES);
  localparam logic [MD_CNT_W-1:0] MD_LOAD  = MD_CNT_W'(MD_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] MD_ONE   = MD_CNT_W'(1);
  localparam logic [MD_CNT_W-1:0] MD_ZERO  = {MD_CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [MD_CNT_W-1:0] md_cnt_r;
  logic [MD_CNT_W-1:0] md_cnt_nxt_s;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                lu_stall_s;
  logic                md_last_s;

  hazard_load_use #(
    .RA_W(RA_W)
  ) u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu_stall   (lu_stall_s)
  );

  // md_cnt counts down the MUL/DIV cycles still owed after the start cycle.
  assign md_last_s = (state_r == MD_BUSY) & (md_cnt_r == MD_ONE);

  // Next-state and MUL/DIV counter; nothing advances while memory holds the pipe.
  always_comb begin
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    if (mem_wait) begin
      state_nxt_s  = state_r;
      md_cnt_nxt_s = md_cnt_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (ex_md_start) begin
            state_nxt_s  = MD_BUSY;
            md_cnt_nxt_s = MD_LOAD;
          end else begin
            state_nxt_s  = IDLE;
            md_cnt_nxt_s = MD_ZERO;
          end
        end
        MD_BUSY: begin
          if (md_cnt_r == MD_ONE) begin
            state_nxt_s  = IDLE;
            md_cnt_nxt_s = MD_ZERO;
          end else begin
            state_nxt_s  = MD_BUSY;
            md_cnt_nxt_s = md_cnt_r - MD_ONE;
          end
        end
        default: begin
          state_nxt_s  = IDLE;
          md_cnt_nxt_s = MD_ZERO;
        end
      endcase
    end
  end

  // FSM and MUL/DIV counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      md_cnt_r <= MD_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

  // Priority mux for enables/flushes; reset is folded in so outputs are quiet during reset.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst) begin
      pc_en = 1'b0;
    end else if (mem_wait) begin
      pc_en = 1'b0;
    end else if ((state_r == MD_BUSY) || ex_md_start) begin
      exmem_flush = 1'b1;
    end else if (ex_br_taken) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_stall_s) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
    end else begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      idex_en = 1'b1;
    end
  end

  assign md_busy = rst & (state_r == MD_BUSY);
  assign md_done = rst & ~mem_wait & md_last_s;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (!pc_en && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule
